// File: rtl/text_write_sequencer.sv
// Text-mode write sequencer: buffers host bytes, interprets control codes,
// tracks the cursor/attribute and drives the video memory write port.
module text_write_sequencer #(
  parameter int COLS       = 100,
  parameter int ROWS       = 37,
  parameter int XW         = 7,
  parameter int YW         = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  input  logic          attr_load,
  input  logic [6:0]    attr_value,
  input  logic          hold,
  output logic          write,
  output logic [XW-1:0] xtextwrite,
  output logic [YW-1:0] ytextwrite,
  output logic [14:0]   value,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLEAR = 2'd2} state_t;

  state_t        state, state_next;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [7:0]    cur_byte;
  logic [6:0]    attr;
  logic [XW-1:0] clr_x, clr_x_next, cx_next, wr_x;
  logic [YW-1:0] clr_y, clr_y_next, cy_next, wr_y;
  logic [7:0]    wr_char;
  logic          do_write;

  // Handshake: a byte transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on the registered occupancy count.
  assign in_ready  = (count != FULL_COUNT);
  assign push      = in_valid & in_ready;
  assign busy      = (count != '0) || (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0 && !hold) state_next = EXEC;
      EXEC:    state_next = (cur_byte == 8'h0C) ? CLEAR : IDLE;
      CLEAR:   if (!hold && clr_x == X_LAST && clr_y == Y_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    do_write   = 1'b0;
    wr_x       = cursor_x;
    wr_y       = cursor_y;
    wr_char    = cur_byte;
    cx_next    = cursor_x;
    cy_next    = cursor_y;
    clr_x_next = clr_x;
    clr_y_next = clr_y;
    case (state)
      IDLE: pop = (count != '0) && !hold;
      EXEC: begin
        if (cur_byte >= 8'h20 && cur_byte != 8'h7F) begin
          do_write = 1'b1;
          if (cursor_x == X_LAST) begin
            cx_next = '0;
            cy_next = (cursor_y == Y_LAST) ? '0 : cursor_y + 1'b1;
          end else begin
            cx_next = cursor_x + 1'b1;
          end
        end else begin
          case (cur_byte)
            8'h0D: cx_next = '0;
            8'h0A: cy_next = (cursor_y == Y_LAST) ? '0 : cursor_y + 1'b1;
            8'h08: if (cursor_x != '0) cx_next = cursor_x - 1'b1;
            8'h0C: begin
              clr_x_next = '0;
              clr_y_next = '0;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        if (!hold) begin
          do_write = 1'b1;
          wr_x     = clr_x;
          wr_y     = clr_y;
          wr_char  = 8'h20;
          if (clr_x == X_LAST) begin
            clr_x_next = '0;
            clr_y_next = (clr_y == Y_LAST) ? '0 : clr_y + 1'b1;
            if (clr_y == Y_LAST) begin
              cx_next = '0;
              cy_next = '0;
            end
          end else begin
            clr_x_next = clr_x + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Byte storage has no reset; occupancy and pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_byte   <= '0;
      attr       <= 7'b0000111;
      cursor_x   <= '0;
      cursor_y   <= '0;
      clr_x      <= '0;
      clr_y      <= '0;
      write      <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_byte <= fifo_mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
      if (attr_load) attr <= attr_value;
      cursor_x <= cx_next;
      cursor_y <= cy_next;
      clr_x    <= clr_x_next;
      clr_y    <= clr_y_next;
      write    <= do_write;
      // Address and value hold their last values between strobes.
      if (do_write) begin
        xtextwrite <= wr_x;
        ytextwrite <= wr_y;
        value      <= {attr, wr_char};
      end
    end
  end

endmodule

// File: tb/tb_text_write_sequencer.sv
// Bench for text_write_sequencer on a 4x3 screen: a cursor/attribute model
// predicts every video-memory write and literal checks pin key results.
module tb_text_write_sequencer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int XW   = 2;
  localparam int YW   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_byte = 8'h00;
  logic          attr_load = 1'b0;
  logic [6:0]    attr_value = 7'h00;
  logic          hold = 1'b0;
  logic          write;
  logic [XW-1:0] xtextwrite;
  logic [YW-1:0] ytextwrite;
  logic [14:0]   value;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic          busy;
  logic [1:0]    fsm_state;

  text_write_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .attr_load(attr_load), .attr_value(attr_value),
    .hold(hold), .write(write), .xtextwrite(xtextwrite),
    .ytextwrite(ytextwrite), .value(value), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic hold_prev = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    hold_prev <= hold;
  end

  // Model state: cursor, attribute, expected writes {x, y, value}.
  int mx, my;
  logic [6:0] mattr;
  logic [XW+YW+14:0] exp_q[$];
  int n_writes = 0, n_clear = 0, last_cyc = 0, acc_cyc = 0;
  logic [XW-1:0] last_x;
  logic [YW-1:0] last_y;
  logic [14:0] last_val;
  logic clear_phase = 1'b0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function void push_exp(input int x, input int y, input logic [7:0] ch);
    exp_q.push_back({XW'(x), YW'(y), mattr, ch});
  endfunction

  function void model_accept(input logic [7:0] b);
    if (b == 8'h0C) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) push_exp(x, y, 8'h20);
      mx = 0;
      my = 0;
    end else if (b >= 8'h20 && b != 8'h7F) begin
      push_exp(mx, my, b);
      mx++;
      if (mx == COLS) begin
        mx = 0;
        my = (my + 1) % ROWS;
      end
    end else if (b == 8'h0D) mx = 0;
    else if (b == 8'h0A) my = (my + 1) % ROWS;
    else if (b == 8'h08 && mx > 0) mx--;
  endfunction

  // Compare process: every write strobe must match the next predicted write.
  always @(negedge clk) begin
    if (reset_n && write) begin
      n_writes++;
      last_cyc = cyc;
      last_x   = xtextwrite;
      last_y   = ytextwrite;
      last_val = value;
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [XW+YW+14:0] e;
        e = exp_q.pop_front();
        chk("write_x", xtextwrite, e[XW+YW+14 -: XW]);
        chk("write_y", ytextwrite, e[YW+14 -: YW]);
        chk("write_value", value, e[14:0]);
      end
      if (clear_phase) begin
        n_clear++;
        chk("clear_no_write_under_hold", hold_prev, 0);
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    hold = 1'b0;
    attr_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mx = 0;
    my = 0;
    mattr = 7'b0000111;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_ready_timeout", in_ready, 1);
    @(posedge clk);
    model_accept(b);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(negedge clk);
    #1;
    chk("idle_reached", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, acc;
    logic was_ready;

    // Reset values
    apply_reset();
    chk("rst_write", write, 0);
    chk("rst_x", xtextwrite, 0);
    chk("rst_y", ytextwrite, 0);
    chk("rst_value", value, 0);
    chk("rst_cursor_x", cursor_x, 0);
    chk("rst_cursor_y", cursor_y, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);

    // Single 'A': latency 2, default attribute
    send_byte(8'h41);
    wait_idle();
    chk("a_writes", n_writes, 1);
    chk("a_latency", last_cyc - acc_cyc, 2);
    chk("a_value", last_val, 15'h0741);
    chk("a_addr", {last_x, last_y}, 0);
    chk("a_cursor_x", cursor_x, 1);
    chk("a_cursor_y", cursor_y, 0);

    // Full screen of printable bytes wraps the cursor to (0,0)
    apply_reset();
    for (int i = 0; i < COLS * ROWS; i++) send_byte(8'(8'h30 + i));
    wait_idle();
    chk("wrap_cursor_x", cursor_x, 0);
    chk("wrap_cursor_y", cursor_y, 0);
    chk("wrap_last_x", last_x, 3);
    chk("wrap_last_y", last_y, 2);
    send_byte(8'h5A);
    wait_idle();
    chk("wrap_next_addr", {last_x, last_y}, 0);
    chk("wrap_next_value", last_val, 15'h075A);

    // Control codes: A B BS C CR LF, then BS at column 0
    apply_reset();
    w0 = n_writes;
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h08);
    send_byte(8'h43);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h07);
    send_byte(8'h7F);
    wait_idle();
    chk("ctl_writes", n_writes - w0, 3);
    chk("ctl_c_addr", {last_x, last_y}, 4'b0100);
    chk("ctl_c_value", last_val, 15'h0743);
    chk("ctl_cursor_x", cursor_x, 0);
    chk("ctl_cursor_y", cursor_y, 1);
    send_byte(8'h08);
    wait_idle();
    chk("bs0_cursor_x", cursor_x, 0);
    chk("bs0_cursor_y", cursor_y, 1);

    // Clear with a loaded attribute and hold toggling
    apply_reset();
    attr_value = 7'b1001010;
    attr_load  = 1'b1;
    @(posedge clk);
    mattr = attr_value;
    #1;
    attr_load = 1'b0;
    send_byte(8'h78);
    wait_idle();
    chk("pre_clear_value", last_val, 15'h4A78);
    clear_phase = 1'b1;
    send_byte(8'h0C);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      hold = ~hold;
      if (!busy && exp_q.size() == 0) break;
    end
    hold = 1'b0;
    clear_phase = 1'b0;
    chk("clear_drained", exp_q.size(), 0);
    chk("clear_writes", n_clear, 12);
    chk("clear_value", last_val, 15'h4A20);
    chk("clear_cursor_x", cursor_x, 0);
    chk("clear_cursor_y", cursor_y, 0);
    chk("clear_busy", busy, 0);

    // Back-pressure: hold blocks pops, FIFO fills at 4
    apply_reset();
    w0 = n_writes;
    acc = 0;
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      in_byte   = 8'(8'h61 + i);
      was_ready = in_ready;
      @(posedge clk);
      if (was_ready) begin
        model_accept(in_byte);
        acc++;
      end
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_no_writes", n_writes - w0, 0);
    hold = 1'b0;
    wait_idle();
    chk("bp_writes", n_writes - w0, 4);
    chk("bp_last_value", last_val, 15'h0764);
    chk("bp_in_ready_high", in_ready, 1);
    chk("bp_cursor_y", cursor_y, 1);

    // Asynchronous reset in the middle of a clear
    apply_reset();
    send_byte(8'h0C);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_write", write, 0);
    chk("arst_value", value, 0);
    chk("arst_addr", {xtextwrite, ytextwrite}, 0);
    chk("arst_cursor", {cursor_x, cursor_y}, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    w0 = n_writes;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("arst_no_more_writes", n_writes - w0, 0);
    chk("arst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
